// File: rtl/input_vc_requester.sv
// Input-port requester: per-VC flit FIFOs with a two-state packet FSM, one request
// bit per VC to the allocator, and a registered flit/credit output on each grant.
module input_vc_requester #(
  parameter int vc_Num       = 4,
  parameter int port_Num     = 5,
  parameter int buffer_Depth = 4,
  parameter int flit_Width   = 32,
  localparam int VCW = $clog2(vc_Num),
  localparam int OPW = $clog2(port_Num)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flit_valid_i,
  input  logic [flit_Width-1:0]         flit_i,
  input  logic [VCW-1:0]                flit_vc_i,
  input  logic                          flit_head_i,
  input  logic                          flit_tail_i,
  input  logic [OPW-1:0]                out_port_i,
  output logic [vc_Num-1:0]             request_o,
  output logic [vc_Num-1:0][OPW-1:0]    out_port_o,
  input  logic [vc_Num-1:0]             grant_i,
  output logic                          flit_valid_o,
  output logic [flit_Width-1:0]         flit_o,
  output logic [VCW-1:0]                flit_vc_o,
  output logic                          credit_valid_o,
  output logic [VCW-1:0]                credit_vc_o,
  output logic                          error_o
);

  localparam int PW = $clog2(buffer_Depth);
  localparam int CW = PW + 1;
  localparam int EW = flit_Width + 2 + OPW;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  logic [vc_Num-1:0]                 empty, is_idle, front_head, front_tail;
  logic [vc_Num-1:0]                 push_err, discard, gnt_pop;
  logic [vc_Num-1:0][flit_Width-1:0] front_flit;
  logic [vc_Num-1:0][OPW-1:0]        front_port;
  logic                              grant_multi, grant_err;

  // A multi-hot grant pops nothing; a grant bit without a matching request is ignored.
  assign grant_multi = |(grant_i & (grant_i - 1'b1));
  assign gnt_pop     = grant_multi ? '0 : (grant_i & request_o);
  assign grant_err   = grant_multi | (|(grant_i & ~request_o));
  assign discard     = is_idle & ~empty & ~front_head;
  assign request_o   = ~is_idle & ~empty;

  for (genvar gi = 0; gi < vc_Num; gi++) begin : g_vc
    logic [EW-1:0]  mem_q [buffer_Depth];
    logic [PW-1:0]  rd_q, wr_q;
    logic [CW-1:0]  cnt_q;
    logic [OPW-1:0] port_q;
    state_t         state_q;
    logic           push, pop, full, push_ok;

    assign push          = flit_valid_i && (flit_vc_i == VCW'(gi));
    assign pop           = gnt_pop[gi] | discard[gi];
    assign full          = (cnt_q == CW'(buffer_Depth));
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign push_ok       = push && (!full || pop);
    assign push_err[gi]  = push && full && !pop;
    assign empty[gi]     = (cnt_q == '0);
    assign is_idle[gi]   = (state_q == IDLE);
    assign out_port_o[gi] = port_q;
    assign {front_flit[gi], front_head[gi], front_tail[gi], front_port[gi]} = mem_q[rd_q];

    always_ff @(posedge clk) begin
      if (push_ok) begin
        mem_q[wr_q] <= {flit_i, flit_head_i, flit_tail_i, out_port_i};
      end
    end

    always_ff @(posedge clk) begin
      if (rst_n) begin
        rd_q    <= '0;
        wr_q    <= '0;
        cnt_q   <= '0;
        port_q  <= '0;
        state_q <= IDLE;
      end else begin
        if (push_ok) wr_q <= wr_q + PW'(1);
        if (pop)     rd_q <= rd_q + PW'(1);
        if (push_ok && !pop)      cnt_q <= cnt_q + CW'(1);
        else if (!push_ok && pop) cnt_q <= cnt_q - CW'(1);
        case (state_q)
          IDLE: if (!empty[gi] && front_head[gi]) begin
            state_q <= REQ;
            port_q  <= front_port[gi];
          end
          REQ: if (gnt_pop[gi] && front_tail[gi]) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic                  sel_vld;
  logic [VCW-1:0]        sel_vc;
  logic [flit_Width-1:0] sel_flit;
  logic                  valid_q, error_q;
  logic [VCW-1:0]        vc_q;
  logic [flit_Width-1:0] flit_q;

  always_comb begin
    sel_vld  = 1'b0;
    sel_vc   = '0;
    sel_flit = '0;
    for (int v = 0; v < vc_Num; v++) begin
      if (gnt_pop[v]) begin
        sel_vld  = 1'b1;
        sel_vc   = VCW'(v);
        sel_flit = front_flit[v];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_q <= 1'b0;
      vc_q    <= '0;
      flit_q  <= '0;
      error_q <= 1'b0;
    end else begin
      valid_q <= sel_vld;
      if (sel_vld) begin
        vc_q   <= sel_vc;
        flit_q <= sel_flit;
      end
      error_q <= error_q | grant_err | (|discard) | (|push_err);
    end
  end

  assign flit_valid_o   = valid_q;
  assign flit_o         = flit_q;
  assign flit_vc_o      = vc_q;
  assign credit_valid_o = valid_q;
  assign credit_vc_o    = vc_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_input_vc_requester.sv
// Scenario bench for input_vc_requester: a scoreboard of expected departing flits
// plus per-scenario inline checks of requests, ports and the error flag.
module tb_input_vc_requester;

  localparam int VN = 4, PN = 5, BD = 4, FW = 32, VCW = 2, OPW = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flit_valid_i;
  logic [FW-1:0]          flit_i;
  logic [VCW-1:0]         flit_vc_i;
  logic                   flit_head_i, flit_tail_i;
  logic [OPW-1:0]         out_port_i;
  logic [VN-1:0]          request_o;
  logic [VN-1:0][OPW-1:0] out_port_o;
  logic [VN-1:0]          grant_i;
  logic                   flit_valid_o;
  logic [FW-1:0]          flit_o;
  logic [VCW-1:0]         flit_vc_o;
  logic                   credit_valid_o;
  logic [VCW-1:0]         credit_vc_o;
  logic                   error_o;

  input_vc_requester #(
    .vc_Num(VN), .port_Num(PN), .buffer_Depth(BD), .flit_Width(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .flit_valid_i(flit_valid_i), .flit_i(flit_i), .flit_vc_i(flit_vc_i),
    .flit_head_i(flit_head_i), .flit_tail_i(flit_tail_i), .out_port_i(out_port_i),
    .request_o(request_o), .out_port_o(out_port_o), .grant_i(grant_i),
    .flit_valid_o(flit_valid_o), .flit_o(flit_o), .flit_vc_o(flit_vc_o),
    .credit_valid_o(credit_valid_o), .credit_vc_o(credit_vc_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [VCW-1:0] vc;
    logic [FW-1:0]  flit;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Scoreboard consumer: every departing flit must match the oldest expected one.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n && flit_valid_o) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_flit: got vc=%0d flit=%h, required no flit", flit_vc_o, flit_o);
      end else begin
        e = sb.pop_front();
        if (flit_o !== e.flit || flit_vc_o !== e.vc || credit_valid_o !== 1'b1 || credit_vc_o !== e.vc) begin
          n_err++;
          $display("FAIL flit_out: got vc=%0d flit=%h credit=%b/%0d, required vc=%0d flit=%h credit=1/%0d",
                   flit_vc_o, flit_o, credit_valid_o, credit_vc_o, e.vc, e.flit, e.vc);
        end else begin
          $display("flit out vc=%0d flit=%h credit vc=%0d", flit_vc_o, flit_o, credit_vc_o);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_flit();
    flit_valid_i = 1'b0;
    flit_i       = '0;
    flit_vc_i    = '0;
    flit_head_i  = 1'b0;
    flit_tail_i  = 1'b0;
    out_port_i   = '0;
  endtask

  task automatic send(input logic [VCW-1:0] vc, input logic [FW-1:0] d, input logic h,
                      input logic t, input logic [OPW-1:0] p, input bit exp_out);
    exp_t e;
    flit_valid_i = 1'b1;
    flit_vc_i    = vc;
    flit_i       = d;
    flit_head_i  = h;
    flit_tail_i  = t;
    out_port_i   = p;
    if (exp_out) begin
      e.vc   = vc;
      e.flit = d;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b1;
    grant_i = '0;
    no_flit();
    sb.delete();
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++;
    if (request_o !== '0 || out_port_o !== '0 || flit_valid_o !== 1'b0 || credit_valid_o !== 1'b0 || error_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got req=%b port=%h fv=%b cv=%b err=%b, required all 0",
               request_o, out_port_o, flit_valid_o, credit_valid_o, error_o);
    end
    send(2'd1, 32'hC0DE_0000, 1'b1, 1'b0, 3'd3, 1'b1);
    tick();
    send(2'd1, 32'hC0DE_0001, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    no_flit();
    @(negedge clk);
    n_vec++;
    if (request_o !== 4'b0010) begin
      n_err++;
      $display("FAIL reset_midpkt_req: got %b, required 0010", request_o);
    end
    rst_n = 1'b1;
    sb.delete();
    tick();
    tick();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (request_o !== '0 || out_port_o !== '0 || flit_valid_o !== 1'b0 || credit_valid_o !== 1'b0 || error_o !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_c%0d: got req=%b port=%h fv=%b cv=%b err=%b, required all 0",
                 c, request_o, out_port_o, flit_valid_o, credit_valid_o, error_o);
      end
      tick();
    end
    $display("test_reset done");
  endtask

  task automatic test_single_vc_packet();
    logic [VN-1:0] exp_req [7];
    logic          exp_vld [7];
    exp_req = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    exp_vld = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    grant_i = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      no_flit();
      if (c < 3) send(2'd1, 32'hA000_0000 + FW'(c), c == 0, c == 2, (c == 0) ? 3'd3 : 3'd0, 1'b1);
      @(negedge clk);
      n_vec++;
      if (request_o !== exp_req[c] || flit_valid_o !== exp_vld[c]) begin
        n_err++;
        $display("FAIL pkt_c%0d: got req=%b fv=%b, required req=%b fv=%b",
                 c, request_o, flit_valid_o, exp_req[c], exp_vld[c]);
      end
      if (c >= 2) begin
        n_vec++;
        if (out_port_o[1] !== 3'd3) begin
          n_err++;
          $display("FAIL pkt_port_c%0d: got %0d, required 3", c, out_port_o[1]);
        end
      end
      tick();
    end
    grant_i = '0;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL pkt_drain: got %0d flits pending, required 0", sb.size());
    end
    $display("test_single_vc_packet done");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      send(2'd0, 32'hB000_0000 + FW'(c), c == 0, 1'b0, 3'd1, c < 4);
      @(negedge clk);
      if (c == 4) begin
        n_vec++;
        if (error_o !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_err_before: got %b, required 0", error_o);
        end
      end
      tick();
    end
    no_flit();
    @(negedge clk);
    n_vec++;
    if (error_o !== 1'b1 || request_o !== 4'b0001) begin
      n_err++;
      $display("FAIL ovf_err_after: got err=%b req=%b, required err=1 req=0001", error_o, request_o);
    end
    for (int d = 0; d < 6; d++) begin
      grant_i = (d < 4) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (sb.size() != 0 || error_o !== 1'b1 || request_o !== 4'b0000) begin
      n_err++;
      $display("FAIL ovf_drain: got pending=%0d err=%b req=%b, required pending=0 err=1 req=0000",
               sb.size(), error_o, request_o);
    end
    $display("test_overflow done");
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      no_flit();
      grant_i = (c >= 4 && c <= 8) ? 4'b0001 : 4'b0000;
      if (c < 4) send(2'd0, 32'hD000_0000 + FW'(c), c == 0, 1'b0, 3'd2, 1'b1);
      if (c == 4) send(2'd0, 32'hD000_00EE, 1'b0, 1'b1, 3'd0, 1'b1);
      @(negedge clk);
      if (c == 4) begin
        n_vec++;
        if (request_o !== 4'b0001) begin
          n_err++;
          $display("FAIL full_req: got %b, required 0001", request_o);
        end
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (error_o !== 1'b0 || request_o !== 4'b0000 || sb.size() != 0) begin
      n_err++;
      $display("FAIL full_push_pop: got err=%b req=%b pending=%0d, required err=0 req=0000 pending=0",
               error_o, request_o, sb.size());
    end
    $display("test_full_push_pop done");
  endtask

  task automatic test_multi_hot_grant();
    do_reset();
    send(2'd0, 32'hE000_0000, 1'b1, 1'b1, 3'd2, 1'b0);
    tick();
    send(2'd2, 32'hE000_0002, 1'b1, 1'b1, 3'd4, 1'b0);
    tick();
    no_flit();
    tick();
    grant_i = 4'b0101;
    @(negedge clk);
    n_vec++;
    if (request_o !== 4'b0101 || error_o !== 1'b0) begin
      n_err++;
      $display("FAIL mh_before: got req=%b err=%b, required req=0101 err=0", request_o, error_o);
    end
    tick();
    grant_i = '0;
    @(negedge clk);
    n_vec++;
    if (flit_valid_o !== 1'b0 || error_o !== 1'b1 || request_o !== 4'b0101) begin
      n_err++;
      $display("FAIL mh_after: got fv=%b err=%b req=%b, required fv=0 err=1 req=0101",
               flit_valid_o, error_o, request_o);
    end
    tick();
    $display("test_multi_hot_grant done");
  endtask

  task automatic test_stray_grant();
    do_reset();
    grant_i = 4'b1000;
    @(negedge clk);
    n_vec++;
    if (error_o !== 1'b0) begin
      n_err++;
      $display("FAIL stray_before: got err=%b, required 0", error_o);
    end
    tick();
    grant_i = '0;
    @(negedge clk);
    n_vec++;
    if (flit_valid_o !== 1'b0 || credit_valid_o !== 1'b0 || error_o !== 1'b1) begin
      n_err++;
      $display("FAIL stray_after: got fv=%b cv=%b err=%b, required fv=0 cv=0 err=1",
               flit_valid_o, credit_valid_o, error_o);
    end
    tick();
    $display("test_stray_grant done");
  endtask

  task automatic test_back_to_back();
    logic [VN-1:0]  exp_req  [6];
    logic           exp_vld  [6];
    logic [OPW-1:0] exp_port [6];
    exp_req  = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000};
    exp_vld  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_port = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd4, 3'd4};
    do_reset();
    grant_i = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      no_flit();
      if (c == 0) send(2'd2, 32'hF000_000A, 1'b1, 1'b1, 3'd2, 1'b1);
      if (c == 1) send(2'd2, 32'hF000_000B, 1'b1, 1'b1, 3'd4, 1'b1);
      @(negedge clk);
      n_vec++;
      if (request_o !== exp_req[c] || flit_valid_o !== exp_vld[c] || out_port_o[2] !== exp_port[c]) begin
        n_err++;
        $display("FAIL b2b_c%0d: got req=%b fv=%b port=%0d, required req=%b fv=%b port=%0d",
                 c, request_o, flit_valid_o, out_port_o[2], exp_req[c], exp_vld[c], exp_port[c]);
      end
      tick();
    end
    grant_i = '0;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL b2b_drain: got %0d flits pending, required 0", sb.size());
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b1;
    grant_i = '0;
    no_flit();
    test_reset();
    test_single_vc_packet();
    test_overflow();
    test_full_push_pop();
    test_multi_hot_grant();
    test_stray_grant();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
